// File: rtl/memoria_datos_arb.sv
// Shared data memory with two masters (CPU and calculator) arbitrated round-robin.
// Grants are combinational; read data, rvalid and err are registered one cycle after the grant edge.
module memoria_datos_arb #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 32,
  parameter int RESULT_IDX = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              calc_req,
  input  logic              calc_we,
  input  logic [ADDR_W-1:0] calc_addr,
  input  logic [DATA_W-1:0] calc_wdata,
  output logic              calc_gnt,
  output logic              calc_rvalid,
  output logic [DATA_W-1:0] calc_rdata,
  output logic              calc_err,
  output logic [DATA_W-1:0] resultado
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] RES_SEL = IDX_W'(RESULT_IDX);

  // Address is a word index; any bit at or above IDX_W puts it out of range.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> IDX_W) == '0;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic              prio;

  logic              cpu_ok, calc_ok;
  logic [IDX_W-1:0]  cpu_idx, calc_idx;

  logic              cpu_vld_p1, calc_vld_p1;
  logic              cpu_err_p1, calc_err_p1;
  logic [DATA_W-1:0] cpu_rdata_p1, calc_rdata_p1;

  assign cpu_ok   = in_range(cpu_addr);
  assign calc_ok  = in_range(calc_addr);
  assign cpu_idx  = cpu_addr[IDX_W-1:0];
  assign calc_idx = calc_addr[IDX_W-1:0];

  // Stage 0: arbitration; nothing is granted while reset is held.
  assign cpu_gnt  = !rst && cpu_req && (!calc_req || !prio);
  assign calc_gnt = !rst && calc_req && (!cpu_req || prio);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b0;
      cpu_vld_p1  <= 1'b0;
      calc_vld_p1 <= 1'b0;
      cpu_err_p1  <= 1'b0;
      calc_err_p1 <= 1'b0;
    end else begin
      if (cpu_gnt)
        prio <= 1'b1;
      else if (calc_gnt)
        prio <= 1'b0;
      cpu_vld_p1  <= cpu_gnt && !cpu_we;
      calc_vld_p1 <= calc_gnt && !calc_we;
      cpu_err_p1  <= cpu_gnt && !cpu_ok;
      calc_err_p1 <= calc_gnt && !calc_ok;
    end
  end

  // Stage 1: array update and registered read data; the array is cleared by reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[IDX_W'(i)] <= '0;
      cpu_rdata_p1  <= '0;
      calc_rdata_p1 <= '0;
    end else begin
      if (cpu_gnt && cpu_we && cpu_ok)
        mem[cpu_idx] <= cpu_wdata;
      else if (calc_gnt && calc_we && calc_ok)
        mem[calc_idx] <= calc_wdata;
      if (cpu_gnt && !cpu_we)
        cpu_rdata_p1 <= cpu_ok ? mem[cpu_idx] : '0;
      if (calc_gnt && !calc_we)
        calc_rdata_p1 <= calc_ok ? mem[calc_idx] : '0;
    end
  end

  assign cpu_rvalid  = cpu_vld_p1;
  assign calc_rvalid = calc_vld_p1;
  assign cpu_err     = cpu_err_p1;
  assign calc_err    = calc_err_p1;
  assign cpu_rdata   = cpu_rdata_p1;
  assign calc_rdata  = calc_rdata_p1;
  assign resultado   = mem[RES_SEL];

endmodule

// File: tb/tb_memoria_datos_arb.sv
// Bench for memoria_datos_arb: directed scenarios plus a randomized run against a behavioural model.
module tb_memoria_datos_arb;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int RIDX   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid, cpu_err;
  logic [DATA_W-1:0] cpu_rdata;
  logic              calc_req = 1'b0, calc_we = 1'b0;
  logic [ADDR_W-1:0] calc_addr = '0;
  logic [DATA_W-1:0] calc_wdata = '0;
  logic              calc_gnt, calc_rvalid, calc_err;
  logic [DATA_W-1:0] calc_rdata;
  logic [DATA_W-1:0] resultado;

  int n_cmp = 0;
  int n_err = 0;

  memoria_datos_arb #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESULT_IDX(RIDX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .calc_req(calc_req), .calc_we(calc_we), .calc_addr(calc_addr), .calc_wdata(calc_wdata),
    .calc_gnt(calc_gnt), .calc_rvalid(calc_rvalid), .calc_rdata(calc_rdata), .calc_err(calc_err),
    .resultado(resultado)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    calc_req = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return ADDR_W'(16 + $urandom_range(0, 15));
      1:       return $urandom | 32'h8000_0000;
      2:       return ADDR_W'(RIDX);
      default: return ADDR_W'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic test_reset();
    cpu_req = 1'b1; calc_req = 1'b1; rst = 1'b1;
    #2;
    n_cmp++;
    if ({cpu_gnt, calc_gnt} !== 2'b00) begin
      n_err++; $display("FAIL rst_gnt: got %b want 00", {cpu_gnt, calc_gnt});
    end
    tick(); tick();
    idle(); rst = 1'b0;
    #2;
    n_cmp++;
    if ({cpu_gnt, calc_gnt, cpu_rvalid, calc_rvalid, cpu_err, calc_err} !== 6'b0) begin
      n_err++; $display("FAIL rst_ctrl: got %b want 000000",
                        {cpu_gnt, calc_gnt, cpu_rvalid, calc_rvalid, cpu_err, calc_err});
    end
    n_cmp++;
    if ({cpu_rdata, calc_rdata, resultado} !== '0) begin
      n_err++; $display("FAIL rst_data: got %h %h %h want 0", cpu_rdata, calc_rdata, resultado);
    end
    tick();
  endtask

  task automatic test_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3; cpu_wdata = 32'hDEADBEEF;
    #2;
    n_cmp++;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %b want 1", cpu_gnt); end
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if ({cpu_rvalid, cpu_err} !== 2'b00) begin
      n_err++; $display("FAIL wr_novalid: got %b want 00", {cpu_rvalid, cpu_err});
    end
    calc_req = 1'b1; calc_we = 1'b0; calc_addr = 3;
    #2;
    n_cmp++;
    if (calc_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b want 1", calc_gnt); end
    tick();
    calc_req = 1'b0;
    n_cmp++;
    if (calc_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_valid: got %b want 1", calc_rvalid); end
    n_cmp++;
    if (calc_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_data: got %h want deadbeef", calc_rdata);
    end
    tick();
    n_cmp++;
    if (calc_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_pulse: got %b want 0", calc_rvalid); end
  endtask

  task automatic test_contention();
    pulse_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3;
    calc_req = 1'b1; calc_we = 1'b0; calc_addr = 4;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_cmp++;
      if ({cpu_gnt, calc_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_gnt%0d: got %b want %b", i, {cpu_gnt, calc_gnt},
                          (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      n_cmp++;
      if ({cpu_rvalid, calc_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_vld%0d: got %b want %b", i, {cpu_rvalid, calc_rvalid},
                          (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_resultado();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = RIDX; cpu_wdata = 32'h5;
    #2;
    n_cmp++;
    if (resultado !== 32'h0) begin n_err++; $display("FAIL res_before: got %h want 0", resultado); end
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if (resultado !== 32'h5) begin n_err++; $display("FAIL res_after: got %h want 5", resultado); end
    pulse_reset();
    n_cmp++;
    if (resultado !== 32'h0) begin n_err++; $display("FAIL res_rst: got %h want 0", resultado); end
  endtask

  task automatic test_out_of_range();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 0; cpu_wdata = 32'h1234_5678;
    tick();
    cpu_req = 1'b0;
    calc_req = 1'b1; calc_we = 1'b0; calc_addr = 0;
    tick();
    calc_addr = 16;
    #2;
    n_cmp++;
    if (calc_gnt !== 1'b1) begin n_err++; $display("FAIL oor_gnt: got %b want 1", calc_gnt); end
    tick();
    calc_req = 1'b0;
    n_cmp++;
    if ({calc_err, calc_rvalid} !== 2'b11) begin
      n_err++; $display("FAIL oor_flags: got %b want 11", {calc_err, calc_rvalid});
    end
    n_cmp++;
    if (calc_rdata !== 32'h0) begin n_err++; $display("FAIL oor_rdata: got %h want 0", calc_rdata); end
    calc_req = 1'b1; calc_we = 1'b1; calc_addr = 32'h8000_0010; calc_wdata = 32'hFFFF;
    tick();
    calc_req = 1'b0;
    n_cmp++;
    if ({calc_err, calc_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL oor_wr_flags: got %b want 10", {calc_err, calc_rvalid});
    end
    calc_req = 1'b1; calc_we = 1'b0; calc_addr = 0;
    tick();
    calc_req = 1'b0;
    n_cmp++;
    if (calc_rdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL oor_unchanged: got %h want 12345678", calc_rdata);
    end
    n_cmp++;
    if (calc_err !== 1'b0) begin n_err++; $display("FAIL oor_err_clear: got %b want 0", calc_err); end
  endtask

  task automatic test_same_cycle();
    pulse_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 1; cpu_wdata = 32'hA5A5_0001;
    calc_req = 1'b1; calc_we = 1'b0; calc_addr = 1;
    #2;
    n_cmp++;
    if ({cpu_gnt, calc_gnt} !== 2'b10) begin
      n_err++; $display("FAIL sc_first: got %b want 10", {cpu_gnt, calc_gnt});
    end
    tick();
    cpu_req = 1'b0;
    #2;
    n_cmp++;
    if (calc_gnt !== 1'b1) begin n_err++; $display("FAIL sc_second: got %b want 1", calc_gnt); end
    tick();
    calc_req = 1'b0;
    n_cmp++;
    if ({calc_rvalid, calc_rdata} !== {1'b1, 32'hA5A5_0001}) begin
      n_err++; $display("FAIL sc_data: got %b %h want 1 a5a50001", calc_rvalid, calc_rdata);
    end
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2; cpu_wdata = 32'h0BAD_F00D;
    tick();
    cpu_req = 1'b0;
    calc_req = 1'b1; calc_we = 1'b0; calc_addr = 2;
    rst = 1'b1;
    #2;
    n_cmp++;
    if (calc_gnt !== 1'b0) begin n_err++; $display("FAIL rm_gnt: got %b want 0", calc_gnt); end
    tick(); tick();
    n_cmp++;
    if (calc_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_vld: got %b want 0", calc_rvalid); end
    rst = 1'b0;
    #2;
    n_cmp++;
    if (calc_gnt !== 1'b1) begin n_err++; $display("FAIL rm_regnt: got %b want 1", calc_gnt); end
    tick();
    calc_req = 1'b0;
    n_cmp++;
    if ({calc_rvalid, calc_rdata} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL rm_data: got %b %h want 1 0", calc_rvalid, calc_rdata);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] model [DEPTH];
    int   fav;
    bit   pend_c, pend_k, eg_c, eg_k, ok;
    logic exp_cv, exp_ce, exp_kv, exp_ke;
    logic [DATA_W-1:0] exp_cd, exp_kd;
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    fav = 0; pend_c = 0; pend_k = 0; exp_cd = '0; exp_kd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_c) begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rnd_addr(); cpu_wdata = $urandom;
      end
      if (!pend_k) begin
        calc_req = ($urandom_range(0, 3) != 0); calc_we = 1'($urandom_range(0, 1));
        calc_addr = rnd_addr(); calc_wdata = $urandom;
      end
      eg_c = cpu_req && (!calc_req || fav == 0);
      eg_k = calc_req && !eg_c;
      #2;
      n_cmp++;
      if ({cpu_gnt, calc_gnt} !== {eg_c, eg_k}) begin
        n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, {cpu_gnt, calc_gnt}, {eg_c, eg_k});
      end
      exp_cv = 0; exp_ce = 0; exp_kv = 0; exp_ke = 0;
      if (eg_c) begin
        ok = (cpu_addr < DEPTH);
        exp_ce = !ok;
        if (!cpu_we) begin exp_cv = 1; exp_cd = ok ? model[cpu_addr[3:0]] : '0; end
        else if (ok) model[cpu_addr[3:0]] = cpu_wdata;
        fav = 1;
      end else if (eg_k) begin
        ok = (calc_addr < DEPTH);
        exp_ke = !ok;
        if (!calc_we) begin exp_kv = 1; exp_kd = ok ? model[calc_addr[3:0]] : '0; end
        else if (ok) model[calc_addr[3:0]] = calc_wdata;
        fav = 0;
      end
      pend_c = cpu_req && !eg_c;
      pend_k = calc_req && !eg_k;
      tick();
      n_cmp++;
      if ({cpu_rvalid, cpu_err, cpu_rdata} !== {exp_cv, exp_ce, exp_cd}) begin
        n_err++; $display("FAIL rnd_cpu c%0d: got %b %b %h want %b %b %h", c,
                          cpu_rvalid, cpu_err, cpu_rdata, exp_cv, exp_ce, exp_cd);
      end
      n_cmp++;
      if ({calc_rvalid, calc_err, calc_rdata} !== {exp_kv, exp_ke, exp_kd}) begin
        n_err++; $display("FAIL rnd_calc c%0d: got %b %b %h want %b %b %h", c,
                          calc_rvalid, calc_err, calc_rdata, exp_kv, exp_ke, exp_kd);
      end
      n_cmp++;
      if (resultado !== model[RIDX]) begin
        n_err++; $display("FAIL rnd_res c%0d: got %h want %h", c, resultado, model[RIDX]);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_resultado();
    test_out_of_range();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
